// File: rtl/video_mode_pkg.sv
// video_mode_pkg: shared state, config vector and helpers for video_mode_ctrl
package video_mode_pkg;
  typedef enum logic [1:0] {IDLE, CHECK, MUTE, SETTLE} vmc_state_t;
  typedef struct packed {
    logic pal;
    logic border_en;
    logic h40corr;
    logic blender;
    logic m5;
    logic m2;
    logic rs1;
  } vmc_cfg_t;
  localparam logic [6:0] VMC_GEO_MASK = 7'b111_0111;
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return v + {7'd0, ~&v};
  endfunction
endpackage

// File: rtl/video_mode_ctrl_if.sv
// video_mode_ctrl_if: request/VDP inputs and applied config outputs; VIDEO_MODE_CTRL_STATS_EN adds counters
interface video_mode_ctrl_if;
  logic vs_in, pal_req, border_en_req, h40corr_req, blender_req, vdp_m5, vdp_m2, vdp_rs1;
  logic pal, border_en, h40corr, blender, mute, busy;
`ifdef VIDEO_MODE_CTRL_STATS_EN
  logic [7:0] change_cnt, glitch_cnt;
  modport master(output vs_in, pal_req, border_en_req, h40corr_req, blender_req, vdp_m5, vdp_m2, vdp_rs1,
                 input pal, border_en, h40corr, blender, mute, busy, change_cnt, glitch_cnt);
  modport slave(input vs_in, pal_req, border_en_req, h40corr_req, blender_req, vdp_m5, vdp_m2, vdp_rs1,
                output pal, border_en, h40corr, blender, mute, busy, change_cnt, glitch_cnt);
`else
  modport master(output vs_in, pal_req, border_en_req, h40corr_req, blender_req, vdp_m5, vdp_m2, vdp_rs1,
                 input pal, border_en, h40corr, blender, mute, busy);
  modport slave(input vs_in, pal_req, border_en_req, h40corr_req, blender_req, vdp_m5, vdp_m2, vdp_rs1,
                output pal, border_en, h40corr, blender, mute, busy);
`endif
endinterface

// File: rtl/video_mode_ctrl_frame_tick_gen.sv
// frame_tick_gen: one-cycle registered pulse on each falling edge of active-low vsync
module frame_tick_gen (
  input  logic clk,
  input  logic reset,
  input  logic vs_in,
  output logic tick
);
  logic vs_d;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      vs_d <= 1'b0;
      tick <= 1'b0;
    end else begin
      vs_d <= vs_in;
      tick <= vs_d & ~vs_in;
    end
endmodule

// File: rtl/video_mode_ctrl.sv
// video_mode_ctrl: frame-debounced, vsync-aligned config apply with mute window; VIDEO_MODE_CTRL_STATS_EN adds change/glitch counters
module video_mode_ctrl
  import video_mode_pkg::*;
#(
  parameter int STABLE_FRAMES = 2,
  parameter int SETTLE_FRAMES = 2
) (
  input logic clk,
  input logic reset,
  video_mode_ctrl_if.slave vif
);
  localparam int CW = $clog2((STABLE_FRAMES > SETTLE_FRAMES ? STABLE_FRAMES : SETTLE_FRAMES) + 1);
  localparam logic [CW-1:0] STAB_LAST = CW'(STABLE_FRAMES - 1);
  localparam logic [CW-1:0] SET_LAST = CW'(SETTLE_FRAMES - 1);
  logic tick, mute, busy, blend_only;
  vmc_state_t state;
  vmc_cfg_t live, cand, appl, diff;
  logic [CW-1:0] stab_cnt, set_cnt;
  frame_tick_gen u_tick (.clk(clk), .reset(reset), .vs_in(vif.vs_in), .tick(tick));
  assign live = {vif.pal_req, vif.border_en_req, vif.h40corr_req, vif.blender_req,
                 vif.vdp_m5, vif.vdp_m2, vif.vdp_rs1};
  assign diff = cand ^ appl;
  assign blend_only = ~|(diff & VMC_GEO_MASK);
  assign vif.pal = appl.pal;
  assign vif.border_en = appl.border_en;
  assign vif.h40corr = appl.h40corr;
  assign vif.blender = appl.blender;
  assign vif.mute = mute;
  assign vif.busy = busy;
`ifdef VIDEO_MODE_CTRL_STATS_EN
  logic [7:0] change_cnt, glitch_cnt;
  assign vif.change_cnt = change_cnt;
  assign vif.glitch_cnt = glitch_cnt;
`endif
  // CHECK priority: relatch beats revert-to-applied, which beats the frame tick
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= SETTLE;
      cand <= '0;
      appl <= '0;
      stab_cnt <= '0;
      set_cnt <= '0;
      mute <= 1'b1;
      busy <= 1'b1;
`ifdef VIDEO_MODE_CTRL_STATS_EN
      change_cnt <= '0;
      glitch_cnt <= '0;
`endif
    end else
      case (state)
        IDLE:
          if (live != appl) begin
            cand <= live;
            stab_cnt <= '0;
            state <= CHECK;
            busy <= 1'b1;
          end
        CHECK:
          if (live != cand) begin
            cand <= live;
            stab_cnt <= '0;
`ifdef VIDEO_MODE_CTRL_STATS_EN
            glitch_cnt <= sat_inc(glitch_cnt);
`endif
          end else if (live == appl) begin
            state <= IDLE;
            busy <= 1'b0;
          end else if (tick) begin
            if (stab_cnt != STAB_LAST) stab_cnt <= stab_cnt + 1'b1;
            else if (blend_only) begin
              appl.blender <= cand.blender;
              state <= IDLE;
              busy <= 1'b0;
`ifdef VIDEO_MODE_CTRL_STATS_EN
              change_cnt <= sat_inc(change_cnt);
`endif
            end else begin
              state <= MUTE;
              mute <= 1'b1;
            end
          end
        MUTE:
          if (tick) begin
            appl <= cand;
            set_cnt <= '0;
            state <= SETTLE;
`ifdef VIDEO_MODE_CTRL_STATS_EN
            change_cnt <= sat_inc(change_cnt);
`endif
          end
        SETTLE:
          if (tick) begin
            if (set_cnt != SET_LAST) set_cnt <= set_cnt + 1'b1;
            else begin
              state <= IDLE;
              mute <= 1'b0;
              busy <= 1'b0;
            end
          end
      endcase
endmodule

// File: tb/tb_video_mode_ctrl.sv
// tb_video_mode_ctrl: directed scenarios plus random request churn against a frame-level reference model
module tb_video_mode_ctrl;
  localparam int P = 40, STAB = 2, SETL = 2;
  logic clk = 1'b0, rst = 1'b0;
  int n_chk = 0, n_err = 0, fcnt = 0;
  bit [6:0] req = '0;
  video_mode_ctrl_if vif();
  video_mode_ctrl #(.STABLE_FRAMES(STAB), .SETTLE_FRAMES(SETL)) dut (.clk(clk), .reset(rst), .vif(vif));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  // reference: ticks seen since candidate latched, settle countdown, pending geometry apply
  bit [6:0] m_appl, m_cand, live;
  bit m_chk, m_armed, m_settling, m_vs_d, m_tick, tk;
  int m_ticks, m_left, m_changes, m_glitches;
  always @(posedge clk or posedge rst)
    if (rst) begin
      m_appl = '0; m_cand = '0; m_chk = 0; m_armed = 0; m_settling = 1; m_left = SETL;
      m_ticks = 0; m_vs_d = 0; m_tick = 0; m_changes = 0; m_glitches = 0;
    end else begin
      tk = m_tick;
      m_tick = m_vs_d & ~vif.vs_in;
      m_vs_d = vif.vs_in;
      live = {vif.pal_req, vif.border_en_req, vif.h40corr_req, vif.blender_req, vif.vdp_m5, vif.vdp_m2, vif.vdp_rs1};
      if (m_settling) begin
        if (tk && --m_left == 0) m_settling = 0;
      end else if (m_armed) begin
        if (tk) begin m_appl = m_cand; m_armed = 0; m_settling = 1; m_left = SETL; m_changes++; end
      end else if (m_chk) begin
        if (live != m_cand) begin m_cand = live; m_ticks = 0; m_glitches++; end
        else if (live == m_appl) m_chk = 0;
        else if (tk && ++m_ticks == STAB) begin
          m_chk = 0;
          if ((m_cand ^ m_appl) == 7'b0001000) begin m_appl = m_cand; m_changes++; end
          else m_armed = 1;
        end
      end else if (live != m_appl) begin
        m_cand = live; m_ticks = 0; m_chk = 1;
      end
    end
  always @(negedge clk) begin
    check("mute", 8'(vif.mute), 8'(m_armed | m_settling));
    check("busy", 8'(vif.busy), 8'(m_chk | m_armed | m_settling));
    check("cfg", 8'({vif.pal, vif.border_en, vif.h40corr, vif.blender}), 8'(m_appl[6:3]));
`ifdef VIDEO_MODE_CTRL_STATS_EN
    check("change_cnt", vif.change_cnt, 8'(m_changes > 255 ? 255 : m_changes));
    check("glitch_cnt", vif.glitch_cnt, 8'(m_glitches > 255 ? 255 : m_glitches));
`endif
  end
  task automatic step();
    @(negedge clk);
    fcnt = (fcnt + 1) % P;
    vif.vs_in = fcnt < P - 4;
  endtask
  task automatic go(input int n);
    repeat (n) step();
  endtask
  task automatic to_fc(input int v);
    do step(); while (fcnt != v);
  endtask
  task automatic drive();
    {vif.pal_req, vif.border_en_req, vif.h40corr_req, vif.blender_req, vif.vdp_m5, vif.vdp_m2, vif.vdp_rs1} = req;
  endtask
  initial begin
    vif.vs_in = 1'b1;
    drive();
    #1 rst = 1'b1;
    go(3);
    rst = 1'b0;
    go(3 * P);
    check("boot_mute", 8'(vif.mute), 8'd0);
    check("boot_busy", 8'(vif.busy), 8'd0);
    to_fc(10); req[5] = 1; drive();
    go(4 * P);
    check("border_mute_win", 8'(vif.mute), 8'd1);
    check("border_applied", 8'(vif.border_en), 8'd1);
    go(P);
    check("border_unmute", 8'(vif.mute), 8'd0);
    to_fc(10); req[3] = 1; drive();
    go(P);
    check("blend_early", 8'(vif.blender), 8'd0);
    go(P);
    check("blend_applied", 8'(vif.blender), 8'd1);
    to_fc(10); req[6] = 1; drive();
    go(P);
    req[6] = 0; drive();
    go(2 * P);
    check("pal_revert", 8'(vif.pal), 8'd0);
    check("pal_revert_busy", 8'(vif.busy), 8'd0);
    to_fc(5); req[4] = 1; drive();
    repeat (4) begin to_fc(37); req[0] ^= 1'b1; drive(); end
    step();
    check("glitch_busy", 8'(vif.busy), 8'd1);
    check("glitch_no_apply", 8'(vif.h40corr), 8'd0);
    go(6 * P);
    req = '0; drive();
    go(8 * P);
    to_fc(5); req[5] = 1; drive();
    for (int i = 0; i < 4 * P && !m_armed; i++) step();
    check("arm_wait", 8'(m_armed), 8'd1);
    go(5);
    #1 rst = 1'b1;
    #1;
    check("rst_border", 8'(vif.border_en), 8'd0);
    check("rst_mute", 8'(vif.mute), 8'd1);
    check("rst_busy", 8'(vif.busy), 8'd1);
    go(3);
    rst = 1'b0;
    repeat (6000) begin
      step();
      if (fcnt == 37 ? $urandom_range(0, 3) == 0 : $urandom_range(0, 29) == 0) begin
        req[$urandom_range(0, 6)] ^= 1'b1;
        drive();
      end
      if (fcnt == 2 && $urandom_range(0, 149) == 0) begin
        #1 rst = 1'b1;
        go(2);
        rst = 1'b0;
      end
    end
    go(10 * P);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
